// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, default
// reset pc, FIFO entry layout and small pc helpers.
// Optional feature macro: IFU_MISALIGN_EXC_EN adds a misalign flag to each entry.
package ifu_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
`ifdef IFU_MISALIGN_EXC_EN
    logic        misalign;
`endif
  } ifu_entry_t;

  // Sequential fetch step; wraps naturally at the top of the address space.
  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Word-align a pc by clearing its two low bits.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer for the fetch unit: synchronous FIFO with flush,
// occupancy output and simultaneous push/pop at any fill level.
// A push in the flush cycle lands as the sole entry of the emptied FIFO.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  ifu_entry_t               pushData_i,
  input  logic                     pop_i,
  output ifu_entry_t               head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrIdx;
  logic [CW-1:0] count_q, count_d;
  logic          doPush, doPop;
  ifu_entry_t    mem_q [DEPTH];

  assign doPop   = pop_i & (count_q != '0) & ~flush_i;
  assign doPush  = push_i & (flush_i | (count_q != FULL) | doPop);
  assign head_o  = mem_q[rdPtr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Pointer and occupancy next-state; flush restarts both pointers at slot 0.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    wrIdx   = wrPtr_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrIdx   = '0;
      wrPtr_d = doPush ? AW'(1) : '0;
      count_d = doPush ? CW'(1) : '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrIdx] <= pushData_i;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// RV32I instruction fetch front-end: issues word requests to instruction
// memory under a credit limit, buffers responses, streams {inst, pc} to
// decode and discards stale responses after a pc redirect.
// Optional feature macro: IFU_MISALIGN_EXC_EN (misaligned redirect yields a
// flagged NOP and halts fetch instead of silently aligning the pc).
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
`ifdef IFU_MISALIGN_EXC_EN
  ,
  output logic        inst_misalign_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   respPc_q, respPc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          started_q;

  logic          active, credit, fetchHalted;
  logic          gntAcc, rvalid, dropping, kept;
  logic          showHead, fifoPop, fifoPush, fifoEmpty;
  logic [CW:0]   inUse;
  logic [CW-1:0] fifoCount;
  ifu_entry_t    pushData, head;

`ifdef IFU_MISALIGN_EXC_EN
  logic halted_q, halted_d;
  logic redirectMisaligned;
  assign redirectMisaligned = redirect_i & (redirect_pc_i[1:0] != 2'b00);
  assign fetchHalted        = halted_q;
`else
  assign fetchHalted        = 1'b0;
`endif

  // started_q keeps every output quiet for the cycle following reset.
  assign active = started_q & ~rst_i;
  assign inUse  = {1'b0, outstanding_q} + {1'b0, fifoCount};
  assign credit = inUse < DEPTH_W;

  // Memory handshake and decode-side presentation of the FIFO head.
  always_comb begin
    imem_req_o   = active & ~redirect_i & ~fetchHalted & credit;
    imem_addr_o  = active ? fetchPc_q : '0;
    gntAcc       = imem_req_o & imem_gnt_i;
    rvalid       = imem_rvalid_i & active;
    dropping     = rvalid & (drop_q != '0);
    kept         = rvalid & (drop_q == '0);
    showHead     = active & ~fifoEmpty;
    inst_valid_o = showHead & ~redirect_i;
    fifoPop      = inst_valid_o & inst_ready_i;
    inst_o       = showHead ? head.inst : '0;
    pc_o         = showHead ? head.pc   : '0;
`ifdef IFU_MISALIGN_EXC_EN
    inst_misalign_o = showHead ? head.misalign : 1'b0;
`endif
  end

  // FIFO write selection: kept responses normally, a flagged NOP on a misaligned redirect.
  always_comb begin
    fifoPush      = kept & ~redirect_i;
    pushData.inst = imem_rdata_i;
    pushData.pc   = respPc_q;
`ifdef IFU_MISALIGN_EXC_EN
    pushData.misalign = 1'b0;
    if (redirectMisaligned) begin
      fifoPush          = 1'b1;
      pushData.inst     = NOP_INST;
      pushData.pc       = redirect_pc_i;
      pushData.misalign = 1'b1;
    end
`endif
  end

  // Fetch/response pc and in-flight bookkeeping; a redirect overrides the normal update.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    respPc_d      = respPc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
`ifdef IFU_MISALIGN_EXC_EN
    halted_d      = halted_q;
`endif
    if (redirect_i) begin
      fetchPc_d     = alignPc(redirect_pc_i);
      respPc_d      = alignPc(redirect_pc_i);
      outstanding_d = outstanding_q + CW'(gntAcc) - CW'(rvalid);
      // Everything still in flight after this edge belongs to the old stream.
      drop_d        = outstanding_q + CW'(gntAcc) - CW'(rvalid);
`ifdef IFU_MISALIGN_EXC_EN
      halted_d      = redirectMisaligned;
`endif
    end else begin
      if (gntAcc)   fetchPc_d = nextPc(fetchPc_q);
      if (kept)     respPc_d  = nextPc(respPc_q);
      if (dropping) drop_d    = drop_q - 1'b1;
      outstanding_d = outstanding_q + CW'(gntAcc) - CW'(rvalid);
    end
  end

  // Fetch state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetchPc_q     <= RESET_PC;
      respPc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      started_q     <= 1'b0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      respPc_q      <= respPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      started_q     <= 1'b1;
    end
  end

`ifdef IFU_MISALIGN_EXC_EN
  // Halt flag: set by a misaligned redirect, cleared by any later redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
`endif

  // A response with nothing in flight means the memory broke protocol.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   imem_rvalid_i |-> (outstanding_q != '0));

  ifu_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (redirect_i),
    .push_i    (fifoPush),
    .pushData_i(pushData),
    .pop_i     (fifoPop),
    .head_o    (head),
    .empty_o   (fifoEmpty),
    .count_o   (fifoCount)
  );

endmodule
